// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 sequential multiplier: state codes,
// operand-mux and shifter select encodings, and the partial-product count.
package mult_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLsb      = 3'd1,
        StMid      = 3'd2,
        StMsb      = 3'd3,
        StCalcDone = 3'd4,
        StErr      = 3'd5
    } state_e;

    // Operand mux selects: first letter picks the a nibble, second the b nibble.
    localparam logic [1:0] LL = 2'b00;
    localparam logic [1:0] LH = 2'b01;
    localparam logic [1:0] HL = 2'b10;
    localparam logic [1:0] HH = 2'b11;

    localparam logic [1:0] SH0 = 2'b00;
    localparam logic [1:0] SH4 = 2'b01;
    localparam logic [1:0] SH8 = 2'b10;

    localparam int unsigned NumPartials = 4;

    // MID is visited for the two cross terms; this is the cnt value on the last visit.
    localparam logic [1:0] MidLastCnt = 2'(NumPartials - 2);

endpackage

// File: rtl/cnt2.sv
// Two-bit counter with asynchronous reset, synchronous clear and increment
// enable; clear wins over increment.
module cnt2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [1:0] q_o
);

    logic [1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the 8x8 sequential multiplier: sequences four 4x4 partial
// products into the reg16 accumulator and flags the finished product.
module seq_mult_ctrl
    import mult_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       sclr_n,
    output logic       clk_ena,
    output logic       done,
    output logic [2:0] state_out
);

    state_e     state_d, state_q;
    logic [1:0] cnt_q;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       launch;

    cnt2 cnt (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .q_o   (cnt_q)
    );

    // Mealy clear-and-enable is gated by reset so no accumulator pulse leaks out during reset.
    assign launch = start & ~reset;

    always_comb begin
        state_d   = state_q;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        input_sel = LL;
        shift_sel = SH0;
        done      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                clk_ena = launch;
                sclr_n  = ~launch;
                if (start) begin
                    state_d = StLsb;
                end
            end
            StLsb: begin
                clk_ena = 1'b1;
                cnt_inc = 1'b1;
                state_d = start ? StErr : StMid;
            end
            StMid: begin
                clk_ena   = 1'b1;
                cnt_inc   = 1'b1;
                shift_sel = SH4;
                if (cnt_q == MidLastCnt) begin
                    input_sel = HL;
                    state_d   = start ? StErr : StMsb;
                end else begin
                    input_sel = LH;
                    state_d   = start ? StErr : StMid;
                end
            end
            StMsb: begin
                clk_ena   = 1'b1;
                input_sel = HH;
                shift_sel = SH8;
                state_d   = start ? StErr : StCalcDone;
            end
            StCalcDone: begin
                done    = 1'b1;
                cnt_clr = 1'b1;
                clk_ena = launch;
                sclr_n  = ~launch;
                state_d = start ? StLsb : StIdle;
            end
            StErr: begin
                cnt_clr = 1'b1;
                state_d = start ? StErr : StIdle;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_out = state_q;

endmodule
